// File: rtl/tty_line_rx.sv
// Serial line receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO,
// with sticky framing-error and overrun status.
module tty_line_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                line,
   input  logic                rd,
   input  logic                err_clr,
   output logic [7:0]          rd_data,
   output logic                empty,
   output logic                full,
   output logic [DEPTH_LOG2:0] count,
   output logic                rx_busy,
   output logic                frame_err,
   output logic                overrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]         H_LOAD  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]         N_LOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t                state, state_next;
   logic                  sync1, ls;
   logic [TW-1:0]         timer, timer_next;
   logic [2:0]            bit_idx, bit_idx_next;
   logic [7:0]            shreg, shreg_next;
   logic                  push, ferr_set;
   logic                  pop, wr_en, ovr_set;
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [7:0]            mem [DEPTH];

   // Two-flop synchroniser, preset to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         ls    <= 1'b1;
      end else begin
         sync1 <= line;
         ls    <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
      end
   end

   // The timer counts down to zero; the sample is taken in the cycle where it reads zero.
   always_comb begin
      state_next   = state;
      timer_next   = (timer == '0) ? timer : timer - TW'(1);
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      push         = 1'b0;
      ferr_set     = 1'b0;
      case (state)
         IDLE: begin
            if (!ls) begin
               state_next = START;
               timer_next = H_LOAD;
            end
         end
         START: begin
            if (timer == '0) begin
               timer_next = N_LOAD;
               if (ls) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  bit_idx_next = 3'd0;
               end
            end
         end
         DATA: begin
            if (timer == '0) begin
               shreg_next   = {ls, shreg[7:1]};
               timer_next   = N_LOAD;
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            if (timer == '0) begin
               timer_next = N_LOAD;
               if (ls) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            if (ls) begin
               state_next = IDLE;
               timer_next = N_LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
   assign pop     = rd && !empty;
   assign wr_en   = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         if (wr_en && !pop) begin
            count <= count + (DEPTH_LOG2 + 1)'(1);
         end else if (pop && !wr_en) begin
            count <= count - (DEPTH_LOG2 + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shreg;
      end
   end

   // Sticky status: a new error event wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_set || (frame_err && !err_clr);
         overrun   <= ovr_set  || (overrun   && !err_clr);
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];
   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_tty_line_rx.sv
// Self-checking bench for tty_line_rx: frames are driven bit by bit, expected bytes
// are queued in a scoreboard and compared as the FIFO is popped.
module tb_tty_line_rx;

   localparam int CPB        = 16;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic                clk = 1'b0;
   logic                reset, line, rd, err_clr;
   logic [7:0]          rd_data;
   logic                empty, full, rx_busy, frame_err, overrun;
   logic [DEPTH_LOG2:0] count;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int line_start = 0;
   int empty_fall_cyc = -1;
   logic prev_empty = 1'b1;

   logic [7:0] exp_q[$];
   int model_cnt = 0;
   bit model_ferr = 1'b0;
   bit model_ovr = 1'b0;

   tty_line_rx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .reset(reset), .line(line), .rd(rd), .err_clr(err_clr),
      .rd_data(rd_data), .empty(empty), .full(full), .count(count),
      .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Records the cycle in which empty was last seen to fall.
   always @(negedge clk) begin
      if (prev_empty && !empty) empty_fall_cyc = cyc;
      prev_empty = empty;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got === expv) passed++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
   endtask

   task automatic checkFlags(input string tag);
      checkOutput({tag, "_count"}, 32'(count), 32'(model_cnt));
      checkOutput({tag, "_empty"}, 32'(empty), 32'(model_cnt == 0));
      checkOutput({tag, "_full"}, 32'(full), 32'(model_cnt == DEPTH));
      checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'(model_ferr));
      checkOutput({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
   endtask

   // Drives one frame; hold_low extends a low line past the stop bit, rd_at pulses rd
   // at that cycle offset, abort_at applies reset at that offset and abandons the frame.
   task automatic applyStimulus(input logic [7:0] data, input bit stop_ok, input int hold_low,
                                input int rd_at, input int abort_at);
      logic [9:0] bits;
      int total;
      bits  = {stop_ok, data, 1'b0};
      total = 10 * CPB + hold_low;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         if (k == 0) line_start = cyc;
         if (abort_at >= 0 && k == abort_at) begin
            line  = 1'b1;
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (2 * CPB) @(negedge clk);
            exp_q.delete();
            model_cnt  = 0;
            model_ferr = 1'b0;
            model_ovr  = 1'b0;
            return;
         end
         line = (k < 10 * CPB) ? bits[k / CPB] : 1'b0;
         if (hold_low > 0 && k == total - 1)
            checkOutput("busy_in_break", 32'(rx_busy), 32'd1);
         if (rd_at >= 0) begin
            if (k == rd_at) begin
               checkOutput("pop_at_stop", 32'(rd_data), 32'(exp_q.pop_front()));
               model_cnt--;
               rd = 1'b1;
            end else begin
               rd = 1'b0;
            end
         end
      end
      @(negedge clk);
      line = 1'b1;
      rd   = 1'b0;
      if (stop_ok) begin
         if (model_cnt < DEPTH) begin
            exp_q.push_back(data);
            model_cnt++;
         end else begin
            model_ovr = 1'b1;
         end
      end else begin
         model_ferr = 1'b1;
      end
   endtask

   task automatic popByte(input string tag);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_model_empty"}, 32'd1, 32'd0);
      end else begin
         checkOutput(tag, 32'(rd_data), 32'(exp_q.pop_front()));
         checkOutput({tag, "_not_empty"}, 32'(empty), 32'd0);
         model_cnt--;
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic pulseErrClr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr    = 1'b0;
      model_ferr = 1'b0;
      model_ovr  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      line    = 1'b1;
      rd      = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkFlags("reset");
      checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
      checkOutput("reset_busy", 32'(rx_busy), 32'd0);

      $display("[TB] single frame 0x41");
      applyStimulus(8'h41, 1'b1, 0, -1, -1);
      checkOutput("latency", 32'(empty_fall_cyc - line_start), 32'd155);
      checkFlags("f41");
      popByte("pop_41");
      @(negedge clk);
      checkOutput("after_pop_empty", 32'(empty), 32'd1);
      checkOutput("after_pop_rd_data", 32'(rd_data), 32'h0);

      $display("[TB] start-bit glitch");
      @(negedge clk);
      line = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("glitch_busy", 32'(rx_busy), 32'd1);
      line = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("glitch_idle", 32'(rx_busy), 32'd0);
      checkFlags("glitch");

      $display("[TB] framing error and break");
      applyStimulus(8'h55, 1'b0, 40, -1, -1);
      checkFlags("break");
      repeat (6) @(negedge clk);
      checkOutput("break_released", 32'(rx_busy), 32'd0);
      applyStimulus(8'h12, 1'b1, 0, -1, -1);
      checkFlags("after_break");
      popByte("pop_12");
      pulseErrClr();
      checkFlags("ferr_cleared");

      $display("[TB] overrun with 17 frames");
      for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 0, -1, -1);
      checkFlags("overrun");
      for (int i = 0; i < 16; i++) popByte("pop_seq");
      @(negedge clk);
      checkOutput("drained_empty", 32'(empty), 32'd1);
      pulseErrClr();
      checkFlags("ovr_cleared");

      $display("[TB] pop coinciding with push into full FIFO");
      for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b1, 0, -1, -1);
      checkFlags("refill");
      applyStimulus(8'hA5, 1'b1, 0, 154, -1);
      checkFlags("pop_push_full");
      for (int i = 0; i < 16; i++) popByte("pop_after_a5");
      checkFlags("drained2");

      $display("[TB] reset mid-frame");
      applyStimulus(8'h99, 1'b1, 0, -1, 85);
      checkFlags("mid_reset");
      checkOutput("mid_reset_busy", 32'(rx_busy), 32'd0);
      applyStimulus(8'h7E, 1'b1, 0, -1, -1);
      checkFlags("after_reset");
      popByte("pop_7e");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
